seg7_capture: RTL
=================

# seg7_capture

Time-multiplexed seven-segment bus receiver: samples active-low segment lines and active-low digit selects, waits for each pattern to settle, inverts the hex-to-segment encoding back to 4-bit nibbles, and assembles a full display word. It sits on the display-side loopback of the MIPS board. Self-test and debug logic use it to read back what the display path is actually driving. The result is presented through a valid/ready handshake.

## Interface
- `DIGITS`, 8 — number of multiplexed digit positions (1..8).
- `STABLE_CYCLES`, 4 — consecutive identical samples needed before a pattern is committed (2..255).
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `seg_in` input [0:6] — segments a..g, active-low; `seg_in[0]` is segment a.
- `dig_sel` input [DIGITS-1:0] — digit enables, active-low; a valid select has exactly one bit at 0.
- `word_out` output [4*DIGITS-1:0] — snapshot of captured nibbles; digit i occupies bits [4i+3:4i].
- `nib_valid` output [DIGITS-1:0] — snapshot; digit i held a decodable hex glyph.
- `err_digit` output [DIGITS-1:0] — snapshot; digit i held a lit pattern that is not in the glyph set.
- `out_valid` output 1 — snapshot available.
- `out_ready` input 1 — consumer accepts the snapshot.
- `err_count` output 8 — present only with the macro in Configuration.

## Operation
- **Input sampling:** `{dig_sel, seg_in}` is registered every cycle into `smp`.
- **Stability counter `cnt`:**
  - If the incoming value equals `smp`, `cnt` increments, saturating at `STABLE_CYCLES`.
  - Otherwise `cnt` loads 1.
- **Commit:** happens exactly once per stable episode, on the cycle `cnt` transitions to `STABLE_CYCLES`, and only if `dig_sel` is one-hot-low. Selects with no zero bit or several zero bits never commit.
- **Glyph set (seg a..g → nibble):**
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0001100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
- **Per-commit update of the live registers for selected digit i:**
  - Pattern in the glyph set: nibble written, valid=1, err=0.
  - 1111111 (blank): valid=0, err=0, nibble unchanged.
  - Any other pattern: err=1, valid=0, nibble unchanged.
  - In every case, `seen[i]` is set to 1.
- **Frame FSM:**
  - COLLECT: when `seen` is all ones, copy the live registers into the snapshot, set `out_valid`, and go to PRESENT.
  - PRESENT: the snapshot is frozen while commits continue into the live registers and `seen`. When `out_valid && out_ready`, clear `seen`, drop `out_valid`, and return to COLLECT.
- **Simultaneous events:** a commit in the same cycle as the accept sets its `seen` bit, and the set wins over the clear.

## Timing
- **Reset values:**
  - `word_out`, `nib_valid`, `err_digit`, `err_count`: 0.
  - `out_valid`: 0.
  - Internal `smp`, `cnt`, `seen`, and live registers: 0.
  - FSM state: COLLECT.
- **Reset mid-frame:** discards any partial frame and any pending snapshot.
- **Commit latency:** if a value is first present at edge E0 and held, the live registers update at edge E0+STABLE_CYCLES-1.
- **Snapshot latency:** `out_valid` rises one edge after the commit that completes `seen`.
- **Handshake rules:**
  - `out_valid` stays high and the snapshot stays unchanged until it is accepted.
  - `out_ready` is ignored while `out_valid` is 0.
- **Back-to-back frames:** the next `out_valid` can rise no earlier than one edge after the accept.

## Configuration
- `SEG7_CAPTURE_ERRCNT_EN` defined:
  - Adds the `err_count` port, an 8-bit counter.
  - Increments once per commit that sets an err bit.
  - Saturates at 255 and clears on `rst`.
- `SEG7_CAPTURE_ERRCNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Settle time:** with `STABLE_CYCLES`=4, drive digit 0 select (`dig_sel`=8'hFE) with `seg_in`=0010010 for 3 cycles, then change it.
  - Required: no commit.
  - Hold it 4 cycles instead: live nibble 0 = 2.
- **Full frame:** scan digits 0..7 with glyphs for 1,2,3,4,5,6,7,8, holding each 5 cycles, with `out_ready`=0.
  - Required: `out_valid`=1, `word_out`=32'h87654321, `nib_valid`=8'hFF.
  - Snapshot stays frozen while the scan continues.
- **Invalid, blank and bad-select cases:**
  - Digit 3 with pattern 1111110: `err_digit[3]`=1 and, with the macro defined, `err_count`=1.
  - Digit 5 blank (1111111): `nib_valid[5]`=0 and `err_digit[5]`=0.
  - `dig_sel`=8'hFC held 10 cycles: no commit.
- **Accept collision:** assert `out_ready` on the same edge as the digit-2 commit.
  - Required: `out_valid` falls and `seen` afterwards equals 8'h04.
- **Reset mid-frame:** assert `rst` after 4 digits have been captured.
  - Required: all outputs 0 and `out_valid` stays 0 until a complete new 8-digit scan.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Bus bundle for seg7_capture: multiplexed display lines in, snapshot plus valid/ready out.
// With SEG7_CAPTURE_ERRCNT_EN defined the bundle also carries the 8-bit err_count.
interface seg7_capture_if #(
    parameter int DIGITS = 8
);
    logic [0:6]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] word_out;
    logic [DIGITS-1:0]   nib_valid;
    logic [DIGITS-1:0]   err_digit;
    logic                out_valid;
    logic                out_ready;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0]          err_count;
`endif

    // master: the capture block (produces the snapshot); slave: the consumer / display driver side
    modport master (
        input  seg_in,
        input  dig_sel,
        input  out_ready,
`ifdef SEG7_CAPTURE_ERRCNT_EN
        output err_count,
`endif
        output word_out,
        output nib_valid,
        output err_digit,
        output out_valid
    );

    modport slave (
        output seg_in,
        output dig_sel,
        output out_ready,
`ifdef SEG7_CAPTURE_ERRCNT_EN
        input  err_count,
`endif
        input  word_out,
        input  nib_valid,
        input  err_digit,
        input  out_valid
    );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment loopback receiver: debounces each digit pattern, decodes it back to a nibble
// and presents a full-display snapshot over valid/ready. Optional SEG7_CAPTURE_ERRCNT_EN adds err_count.
module seg7_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg7_capture_if.master bus
);
    localparam int         SW         = DIGITS + 7;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    // Returns {glyph_hit, nibble}; seg_n is a..g from MSB to LSB, active-low
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg_n);
        logic [4:0] res;
        case (seg_n)
            7'b0000001: res = 5'h10;
            7'b1001111: res = 5'h11;
            7'b0010010: res = 5'h12;
            7'b0000110: res = 5'h13;
            7'b1001100: res = 5'h14;
            7'b0100100: res = 5'h15;
            7'b0100000: res = 5'h16;
            7'b0001111: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0001100: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b1100000: res = 5'h1B;
            7'b0110001: res = 5'h1C;
            7'b1000010: res = 5'h1D;
            7'b0110000: res = 5'h1E;
            7'b0111000: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    function automatic logic single_low(input logic [DIGITS-1:0] sel_n);
        logic [DIGITS-1:0] act;
        act = ~sel_n;
        return (act != {DIGITS{1'b0}}) && ((act & (act - DIGITS'(1))) == {DIGITS{1'b0}});
    endfunction

    logic [SW-1:0]       smp_q, smp_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] live_word_q, live_word_d;
    logic [DIGITS-1:0]   live_valid_q, live_valid_d;
    logic [DIGITS-1:0]   live_err_q, live_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] word_q, word_d;
    logic [DIGITS-1:0]   nib_valid_q, nib_valid_d;
    logic [DIGITS-1:0]   err_digit_q, err_digit_d;
    logic                out_valid_q, out_valid_d;
    state_e              state_q, state_d;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0]          err_count_q, err_count_d;
`endif

    logic [SW-1:0]       sample_s;
    logic                same_s;
    logic                commit_s;
    logic [4:0]          dec_s;
    logic                blank_s;
    logic                bad_s;
    logic [DIGITS-1:0]   seen_set_s;
    logic                seen_clr_s;

    // Sampling, settle counter, glyph decode and live-register update
    always_comb begin
        sample_s = {bus.dig_sel, bus.seg_in};
        same_s   = (sample_s == smp_q);
        smp_d    = sample_s;
        if (!same_s) begin
            cnt_d = 8'd1;
        end else if (cnt_q == STABLE_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Commit only on the transition into STABLE_MAX, so a held pattern commits once
        commit_s = same_s && (cnt_q == (STABLE_MAX - 8'd1)) && single_low(smp_q[SW-1:7]);
        dec_s    = glyph_decode(smp_q[6:0]);
        blank_s  = (smp_q[6:0] == 7'h7F);
        bad_s    = !dec_s[4] && !blank_s;

        live_word_d  = live_word_q;
        live_valid_d = live_valid_q;
        live_err_d   = live_err_q;
        seen_set_s   = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            if (commit_s && !smp_q[7+i]) begin
                live_valid_d[i] = dec_s[4];
                live_err_d[i]   = bad_s;
                seen_set_s[i]   = 1'b1;
                if (dec_s[4]) begin
                    live_word_d[4*i +: 4] = dec_s[3:0];
                end else begin
                    live_word_d[4*i +: 4] = live_word_q[4*i +: 4];
                end
            end else begin
                live_valid_d[i] = live_valid_q[i];
            end
        end

`ifdef SEG7_CAPTURE_ERRCNT_EN
        if (commit_s && bad_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
`endif
    end

    // Frame FSM: snapshot on full coverage, hold until accepted
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        nib_valid_d = nib_valid_q;
        err_digit_d = err_digit_q;
        out_valid_d = out_valid_q;
        seen_clr_s  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (seen_q == {DIGITS{1'b1}}) begin
                    word_d      = live_word_q;
                    nib_valid_d = live_valid_q;
                    err_digit_d = live_err_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_PRESENT: begin
                if (out_valid_q && bus.out_ready) begin
                    seen_clr_s  = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = ST_COLLECT;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_COLLECT;
            end
        endcase
        // A commit landing on the accept edge survives the clear
        seen_d = (seen_clr_s ? {DIGITS{1'b0}} : seen_q) | seen_set_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q        <= {SW{1'b0}};
            cnt_q        <= 8'd0;
            live_word_q  <= {(4*DIGITS){1'b0}};
            live_valid_q <= {DIGITS{1'b0}};
            live_err_q   <= {DIGITS{1'b0}};
            seen_q       <= {DIGITS{1'b0}};
            word_q       <= {(4*DIGITS){1'b0}};
            nib_valid_q  <= {DIGITS{1'b0}};
            err_digit_q  <= {DIGITS{1'b0}};
            out_valid_q  <= 1'b0;
            state_q      <= ST_COLLECT;
`ifdef SEG7_CAPTURE_ERRCNT_EN
            err_count_q  <= 8'd0;
`endif
        end else begin
            smp_q        <= smp_d;
            cnt_q        <= cnt_d;
            live_word_q  <= live_word_d;
            live_valid_q <= live_valid_d;
            live_err_q   <= live_err_d;
            seen_q       <= seen_d;
            word_q       <= word_d;
            nib_valid_q  <= nib_valid_d;
            err_digit_q  <= err_digit_d;
            out_valid_q  <= out_valid_d;
            state_q      <= state_d;
`ifdef SEG7_CAPTURE_ERRCNT_EN
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign bus.word_out  = word_q;
    assign bus.nib_valid = nib_valid_q;
    assign bus.err_digit = err_digit_q;
    assign bus.out_valid = out_valid_q;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    assign bus.err_count = err_count_q;
`endif

endmodule
